// File: rtl/bin2dec_pkg.sv
// Shared definitions for the binary-to-decimal ASCII streamer.
//   state_e     - controller states
//   ASCII_*     - character codes emitted on the output stream
//   min_digits  - decimal digits needed to hold any value below 2**width
package bin2dec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StPrep,
    StEmit
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  // Number of decimal digits of 2**width, i.e. floor(width * log10(2)) + 1.
  // 2**width is never a power of ten, so this is the smallest d with
  // 10**d > 2**width.
  function automatic int unsigned min_digits(input int unsigned width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration over a packed BCD register.
//   bcd_i - current BCD digits, digit 0 in bits [3:0]
//   bit_i - next binary bit (MSB first) shifted into digit 0
//   bcd_o - digits after add-3 correction and a 1-bit left shift
module bcd_dabble_step #(
  parameter int unsigned DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic                bit_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

  // The MSB of the top digit is always 0 after correction when the register is
  // sized for the input width, so it is safe to shift it out.
  always_comb begin
    bcd_o    = adj << 1;
    bcd_o[0] = bit_i;
  end

endmodule

// File: rtl/bin2dec_ascii_stream.sv
// Converts one binary word to its decimal ASCII text, MSD first, as a
// valid/ready character stream. Iterative double-dabble, one bit per cycle.
//   clk, rst               - clock, asynchronous active-high reset
//   in_valid/in_ready      - input word handshake; in_data is the value
//   signed_mode            - treat in_data as two's complement (if SIGNED_EN)
//   lz_suppress            - drop leading zeros
//   out_valid/out_ready    - character handshake; out_data is ASCII
//   out_last               - marks the final character (digit 0)
//   busy                   - high from accept until the last handshake
module bin2dec_ascii_stream
  import bin2dec_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DIGITS    = 5,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              signed_mode,
  input  logic              lz_suppress,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  if (DATA_W < 4 || DATA_W > 64) begin : g_bad_width
    $error("bin2dec_ascii_stream: DATA_W must be within 4..64");
  end
  if (DIGITS < min_digits(DATA_W)) begin : g_bad_digits
    $error("bin2dec_ascii_stream: DIGITS too small for DATA_W");
  end

  state_e            state_q;
  logic [DATA_W-1:0] bin_q;
  logic [BcdW-1:0]   bcd_q;
  logic [CntW-1:0]   cnt_q;
  logic              neg_q;
  logic              lz_q;
  logic              minus_q;
  logic [IdxW-1:0]   idx_q;

  // Sign and magnitude of the incoming word. The magnitude always fits in
  // DATA_W unsigned bits: the most negative value maps to 2**(DATA_W-1).
  logic              in_neg;
  logic [DATA_W-1:0] in_mag;
  assign in_neg = SIGNED_EN && signed_mode && in_data[DATA_W-1];
  assign in_mag = in_neg ? (~in_data + 1'b1) : in_data;

  logic [BcdW-1:0] bcd_next;
  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .bcd_i (bcd_q),
    .bit_i (bin_q[DATA_W-1]),
    .bcd_o (bcd_next)
  );

  // Highest nonzero digit; 0 when the whole value is zero.
  logic [IdxW-1:0] first_nz;
  always_comb begin
    first_nz = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        first_nz = IdxW'(i);
      end
    end
  end

  logic [3:0] cur_nib;
  logic [7:0] digit_char;
  assign cur_nib    = bcd_q[{idx_q, 2'b00} +: 4];
  assign digit_char = ASCII_ZERO + {4'h0, cur_nib};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      lz_q      <= 1'b0;
      minus_q   <= 1'b0;
      idx_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            bin_q    <= in_mag;
            neg_q    <= in_neg;
            lz_q     <= lz_suppress;
            bcd_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StConvert;
          end
        end

        StConvert: begin
          bcd_q <= bcd_next;
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_W - 1)) begin
            state_q <= StPrep;
          end
        end

        StPrep: begin
          idx_q   <= lz_q ? first_nz : IdxW'(DIGITS - 1);
          minus_q <= neg_q;
          state_q <= StEmit;
        end

        StEmit: begin
          // Load a new character when the slot is empty or being consumed;
          // otherwise hold out_data/out_last while the sink stalls.
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state_q   <= StIdle;
            end else begin
              out_valid <= 1'b1;
              if (minus_q) begin
                out_data <= ASCII_MINUS;
                out_last <= 1'b0;
                minus_q  <= 1'b0;
              end else begin
                out_data <= digit_char;
                out_last <= (idx_q == '0);
                if (idx_q != '0) begin
                  idx_q <= idx_q - IdxW'(1);
                end
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2dec_ascii_stream.sv
module tb_bin2dec_ascii_stream;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIGITS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        signed_mode = 1'b0;
  logic        lz_suppress = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  bin2dec_ascii_stream #(
    .DATA_W    (DATA_W),
    .DIGITS    (DIGITS),
    .SIGNED_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .signed_mode (signed_mode),
    .lz_suppress (lz_suppress),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected text from plain decimal arithmetic.
  task automatic build_ref(input logic [15:0] d, input bit sm, input bit lz);
    int unsigned mag;
    int unsigned dig[5];
    int          start;
    bit          neg;
    exp_q.delete();
    neg = sm && d[15];
    mag = neg ? (32'd65536 - {16'h0, d}) : {16'h0, d};
    for (int i = 0; i < 5; i++) begin
      dig[i] = mag % 10;
      mag    = mag / 10;
    end
    start = 4;
    if (lz) begin
      start = 0;
      for (int i = 0; i < 5; i++) if (dig[i] != 0) start = i;
    end
    if (neg) exp_q.push_back(8'h2D);
    for (int i = start; i >= 0; i--) exp_q.push_back(8'(8'h30 + dig[i]));
  endtask

  // Send one word and consume its characters. Timing points are #1 after posedge.
  task automatic run(input logic [15:0] d, input bit sm, input bit lz, input bit rand_ready,
                     input bit poke, input int abort_after, input string tag);
    int waited;
    int k;
    int idx;
    int first_k;
    int last_k;
    bit stalled;
    build_ref(d, sm, lz);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_data     = d;
    signed_mode = sm;
    lz_suppress = lz;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_data     = 16'($urandom);
    signed_mode = 1'($urandom);
    lz_suppress = 1'($urandom);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check({tag, "_ready_fall"}, 32'(in_ready), 32'd0);
    idx = 0; k = 0; first_k = -1; last_k = -1; stalled = 1'b0;
    while (idx < exp_q.size() && k < 400) begin
      if (stalled) check({tag, "_valid_held"}, 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (first_k < 0) first_k = k;
        check({tag, "_char"}, 32'(out_data), 32'(exp_q[idx]));
        check({tag, "_last"}, 32'(out_last), 32'(idx == exp_q.size() - 1));
        if (abort_after > 0 && idx == abort_after) return;
      end
      out_ready = rand_ready ? 1'($urandom) : 1'b1;
      if (poke) begin
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
      end
      stalled = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        idx++;
        if (idx == exp_q.size()) last_k = k;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    check({tag, "_count"}, 32'(idx), 32'(exp_q.size()));
    if (!rand_ready) begin
      check({tag, "_latency"}, 32'(first_k), 32'(DATA_W + 2));
      check({tag, "_back2back"}, 32'(last_k - first_k), 32'(exp_q.size() - 1));
    end
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    run(16'd12345, 1'b0, 1'b0, 1'b0, 1'b0, 0, "u12345");
    run(16'd42,    1'b0, 1'b1, 1'b0, 1'b0, 0, "u42_lz");
    run(16'd42,    1'b0, 1'b0, 1'b0, 1'b0, 0, "u42");
    run(16'd0,     1'b0, 1'b1, 1'b0, 1'b0, 0, "zero_lz");
    run(16'h8000,  1'b1, 1'b0, 1'b0, 1'b0, 0, "s8000");
    run(16'hFFFF,  1'b1, 1'b1, 1'b0, 1'b0, 0, "sffff_lz");
    run(16'hFFFF,  1'b0, 1'b0, 1'b0, 1'b0, 0, "uffff");
    run(16'hFFFF,  1'b0, 1'b0, 1'b1, 1'b1, 0, "bp65535");

    for (int n = 0; n < 20; n++) begin
      run(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, "rand");
    end

    // Abort while the third character of "12345" is presented.
    run(16'd12345, 1'b0, 1'b0, 1'b0, 1'b0, 2, "abort");
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_last", 32'(out_last), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_rel_ready", 32'(in_ready), 32'd1);
    check("abort_rel_valid", 32'(out_valid), 32'd0);
    run(16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 0, "after_abort7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
